picorv32_pcpi_initiator: RTL and testbench

//  Initiator (core-side) end of the PCPI co-processor interface. Accepts one

---
 rtl/picorv32_pcpi_initiator.sv | 181 ++++++++++++++++++
 tb/tb_picorv32_pcpi_initiator.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/picorv32_pcpi_initiator.sv
// Core-side PCPI initiator: takes one request from a host valid/ready port, drives the
// PCPI strobe with a no-wait timeout, and holds the result on a response port.
// Optional completion counters are enabled with `define PCPI_INIT_STATS_EN.
// Host handshakes: a transfer happens on a rising clk edge where valid && ready are both 1.
// A valid side holds its payload stable until that edge.
module picorv32_pcpi_initiator #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_insn,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rd,
    output logic        resp_wr,
    output logic        resp_timeout,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready
`ifdef PCPI_INIT_STATS_EN
    ,
    output logic [31:0] stat_done,
    output logic [31:0] stat_timeout
`endif
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pcpi_valid_q, pcpi_valid_d;
    logic [31:0]   pcpi_insn_q, pcpi_insn_d;
    logic [31:0]   pcpi_rs1_q, pcpi_rs1_d;
    logic [31:0]   pcpi_rs2_q, pcpi_rs2_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_rd_q, resp_rd_d;
    logic          resp_wr_q, resp_wr_d;
    logic          resp_timeout_q, resp_timeout_d;
    logic          done_evt, tmo_evt;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pcpi_valid_d   = pcpi_valid_q;
        pcpi_insn_d    = pcpi_insn_q;
        pcpi_rs1_d     = pcpi_rs1_q;
        pcpi_rs2_d     = pcpi_rs2_q;
        resp_valid_d   = resp_valid_q;
        resp_rd_d      = resp_rd_q;
        resp_wr_d      = resp_wr_q;
        resp_timeout_d = resp_timeout_q;
        done_evt       = 1'b0;
        tmo_evt        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    pcpi_insn_d  = req_insn;
                    pcpi_rs1_d   = req_rs1;
                    pcpi_rs2_d   = req_rs2;
                    pcpi_valid_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A ready on the timeout cycle still counts as a successful completion.
                if (pcpi_ready) begin
                    pcpi_valid_d   = 1'b0;
                    resp_rd_d      = pcpi_rd;
                    resp_wr_d      = pcpi_wr;
                    resp_timeout_d = 1'b0;
                    resp_valid_d   = 1'b1;
                    done_evt       = 1'b1;
                    state_d        = ST_RESP;
                end else if (pcpi_wait) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    pcpi_valid_d   = 1'b0;
                    resp_rd_d      = '0;
                    resp_wr_d      = 1'b0;
                    resp_timeout_d = 1'b1;
                    resp_valid_d   = 1'b1;
                    tmo_evt        = 1'b1;
                    state_d        = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                pcpi_valid_d = 1'b0;
                resp_valid_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            pcpi_valid_q   <= 1'b0;
            pcpi_insn_q    <= '0;
            pcpi_rs1_q     <= '0;
            pcpi_rs2_q     <= '0;
            resp_valid_q   <= 1'b0;
            resp_rd_q      <= '0;
            resp_wr_q      <= 1'b0;
            resp_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pcpi_valid_q   <= pcpi_valid_d;
            pcpi_insn_q    <= pcpi_insn_d;
            pcpi_rs1_q     <= pcpi_rs1_d;
            pcpi_rs2_q     <= pcpi_rs2_d;
            resp_valid_q   <= resp_valid_d;
            resp_rd_q      <= resp_rd_d;
            resp_wr_q      <= resp_wr_d;
            resp_timeout_q <= resp_timeout_d;
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign resp_valid   = resp_valid_q;
    assign resp_rd      = resp_rd_q;
    assign resp_wr      = resp_wr_q;
    assign resp_timeout = resp_timeout_q;
    assign pcpi_valid   = pcpi_valid_q;
    assign pcpi_insn    = pcpi_insn_q;
    assign pcpi_rs1     = pcpi_rs1_q;
    assign pcpi_rs2     = pcpi_rs2_q;

`ifdef PCPI_INIT_STATS_EN
    logic [31:0] stat_done_q, stat_done_d;
    logic [31:0] stat_timeout_q, stat_timeout_d;

    // Counters wrap naturally at 2^32.
    always_comb begin
        stat_done_d    = stat_done_q + {31'd0, done_evt};
        stat_timeout_d = stat_timeout_q + {31'd0, tmo_evt};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_done_q    <= '0;
            stat_timeout_q <= '0;
        end else begin
            stat_done_q    <= stat_done_d;
            stat_timeout_q <= stat_timeout_d;
        end
    end

    assign stat_done    = stat_done_q;
    assign stat_timeout = stat_timeout_q;
`else
    logic unused_evt;
    assign unused_evt = done_evt ^ tmo_evt;
`endif

endmodule

// File: tb/tb_picorv32_pcpi_initiator.sv
// Self-checking bench for picorv32_pcpi_initiator: bench-side PCPI responder, expected-response
// queue filled when a transaction is launched, drained when the DUT presents resp_valid.
module tb_picorv32_pcpi_initiator;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_insn, req_rs1, req_rs2;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rd;
  logic        resp_wr, resp_timeout;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait, pcpi_ready;
`ifdef PCPI_INIT_STATS_EN
  logic [31:0] stat_done, stat_timeout;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_done_exp = 0;
  int n_to_exp = 0;
  // {timeout, wr, rd}
  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  picorv32_pcpi_initiator #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rd(resp_rd), .resp_wr(resp_wr), .resp_timeout(resp_timeout),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready)
`ifdef PCPI_INIT_STATS_EN
    , .stat_done(stat_done), .stat_timeout(stat_timeout)
`endif
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks (all called and returning at a negedge) ----------------
  task automatic issue_req(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
    req_valid = 1'b1;
    req_insn  = insn;
    req_rs1   = rs1;
    req_rs2   = rs2;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Cycle c=0 is the negedge right after acceptance. ready_at<0: never ready.
  task automatic run_responder(input int wait_start, input int ready_at, input logic [31:0] rd,
                               input logic wr, input int max_c, output int valid_cycles);
    valid_cycles = 0;
    for (int c = 0; c < max_c; c++) begin
      if (!pcpi_valid) break;
      valid_cycles++;
      pcpi_wait  = (wait_start >= 0) && (c >= wait_start) && (ready_at < 0 || c < ready_at);
      pcpi_ready = (c == ready_at);
      pcpi_rd    = (c == ready_at) ? rd : $urandom;
      pcpi_wr    = (c == ready_at) ? wr : 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    pcpi_wait  = 1'b0;
    pcpi_ready = 1'b0;
  endtask

  task automatic wait_resp(input int bound, output logic got, output logic [33:0] obs);
    got = 1'b0;
    obs = '0;
    for (int i = 0; i < bound; i++) begin
      if (resp_valid) begin
        got = 1'b1;
        obs = {resp_timeout, resp_wr, resp_rd};
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic push_exp(input logic tmo, input logic wr, input logic [31:0] rd);
    exp_q.push_back({tmo, wr, rd});
    if (tmo) n_to_exp++;
    else n_done_exp++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_cmp++;
    if ({req_ready, pcpi_valid, resp_valid, resp_wr, resp_timeout} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 10000", {req_ready, pcpi_valid, resp_valid, resp_wr, resp_timeout});
    end
    n_cmp++;
    if ({pcpi_insn, pcpi_rs1, pcpi_rs2, resp_rd} !== 128'd0) begin
      n_err++;
      $display("FAIL reset_data: got %h want 0", {pcpi_insn, pcpi_rs1, pcpi_rs2, resp_rd});
    end
  endtask

  task automatic test_div();
    logic signed [31:0] a, b, q;
    logic [33:0] obs, exp;
    logic got;
    int vc;
    a = 32'hFFFF_FFF9;
    b = 32'sd2;
    q = a / b;
    push_exp(1'b0, 1'b1, q);
    issue_req(32'h02C5_C533, a, b);
    n_cmp++;
    if ({pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2} !== {1'b1, 32'h02C5_C533, 32'hFFFF_FFF9, 32'd2}) begin
      n_err++;
      $display("FAIL div_issue: got %b %h %h %h", pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2);
    end
    run_responder(1, 5, q, 1'b1, 50, vc);
    n_cmp++;
    if (vc !== 6 || resp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL div_latency: valid_cycles %0d resp_valid %b want 6 1", vc, resp_valid);
    end
    wait_resp(20, got, obs);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!got || obs !== exp || obs[31:0] !== 32'hFFFF_FFFD) begin
      n_err++;
      $display("FAIL div_resp: got %b %h want %h", got, obs, exp);
    end
    handshake();
    n_cmp++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL div_release: resp_valid %b req_ready %b want 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_timeout();
    logic [33:0] obs, exp;
    logic got;
    int vc;
    push_exp(1'b1, 1'b0, 32'd0);
    issue_req(32'h0200_0033, $urandom, $urandom);
    run_responder(-1, -1, 32'd0, 1'b0, 40, vc);
    n_cmp++;
    if (vc !== TIMEOUT || resp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_len: valid_cycles %0d resp_valid %b want %0d 1", vc, resp_valid, TIMEOUT);
    end
    wait_resp(20, got, obs);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!got || obs !== exp) begin
      n_err++;
      $display("FAIL timeout_resp: got %b %h want %h", got, obs, exp);
    end
    handshake();
  endtask

  task automatic test_slow_wait();
    logic [33:0] obs, exp;
    logic got;
    logic [31:0] rd;
    int vc;
    rd = $urandom;
    push_exp(1'b0, 1'b0, rd);
    issue_req(32'h0200_1033, $urandom, $urandom);
    run_responder(2, 40, rd, 1'b0, 60, vc);
    n_cmp++;
    if (vc !== 41) begin
      n_err++;
      $display("FAIL slow_len: valid_cycles %0d want 41", vc);
    end
    wait_resp(20, got, obs);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!got || obs !== exp) begin
      n_err++;
      $display("FAIL slow_resp: got %b %h want %h", got, obs, exp);
    end
    handshake();
  endtask

  task automatic test_ready_at_limit();
    logic [33:0] obs, exp;
    logic got;
    logic [31:0] rd;
    int vc;
    rd = $urandom;
    push_exp(1'b0, 1'b1, rd);
    issue_req(32'h0200_2033, $urandom, $urandom);
    run_responder(-1, TIMEOUT - 1, rd, 1'b1, 40, vc);
    n_cmp++;
    if (vc !== TIMEOUT) begin
      n_err++;
      $display("FAIL limit_len: valid_cycles %0d want %0d", vc, TIMEOUT);
    end
    wait_resp(20, got, obs);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!got || obs !== exp) begin
      n_err++;
      $display("FAIL limit_resp: got %b %h want %h", got, obs, exp);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    logic [33:0] obs, exp, held;
    logic got;
    logic [31:0] rd_a, rd_b;
    int vc;
    rd_a = $urandom;
    rd_b = $urandom;
    push_exp(1'b0, 1'b1, rd_a);
    issue_req(32'h0200_3033, 32'h1111_1111, 32'h2222_2222);
    run_responder(-1, 3, rd_a, 1'b1, 30, vc);
    wait_resp(20, got, held);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!got || held !== exp) begin
      n_err++;
      $display("FAIL bp_resp: got %b %h want %h", got, held, exp);
    end
    req_valid = 1'b1;
    req_insn  = 32'h0200_4033;
    req_rs1   = 32'h3333_3333;
    req_rs2   = 32'h4444_4444;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      obs = {resp_timeout, resp_wr, resp_rd};
      n_cmp++;
      if (resp_valid !== 1'b1 || obs !== exp || req_ready !== 1'b0 || pcpi_valid !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: valid %b data %h rr %b pv %b want 1 %h 0 0",
                 i, resp_valid, obs, req_ready, pcpi_valid, exp);
      end
    end
    handshake();
    n_cmp++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || pcpi_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_after_hs: rr %b rv %b pv %b want 1 0 0", req_ready, resp_valid, pcpi_valid);
    end
    push_exp(1'b0, 1'b0, rd_b);
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if (pcpi_valid !== 1'b1 || pcpi_insn !== 32'h0200_4033 || pcpi_rs1 !== 32'h3333_3333) begin
      n_err++;
      $display("FAIL bp_second_issue: pv %b insn %h rs1 %h", pcpi_valid, pcpi_insn, pcpi_rs1);
    end
    run_responder(0, 7, rd_b, 1'b0, 30, vc);
    wait_resp(20, got, obs);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!got || obs !== exp) begin
      n_err++;
      $display("FAIL bp_second_resp: got %b %h want %h", got, obs, exp);
    end
    handshake();
  endtask

  task automatic test_reset_mid_issue();
    int seen;
    issue_req(32'h0200_5033, $urandom, $urandom);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (pcpi_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre: pcpi_valid %b want 1", pcpi_valid);
    end
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (pcpi_valid !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_async: pv %b rr %b rv %b want 0 1 0", pcpi_valid, req_ready, resp_valid);
    end
    n_done_exp = 0;
    n_to_exp = 0;
    @(negedge clk);
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      if (i == 2) begin
        pcpi_ready = 1'b1;
        pcpi_rd    = $urandom;
        pcpi_wr    = 1'b1;
      end
      @(negedge clk);
      pcpi_ready = 1'b0;
      if (resp_valid || pcpi_valid) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL rst_no_resp: active cycles %0d want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0] obs, exp;
    logic got, wr, tmo;
    logic [31:0] rd;
    int w, r, vc, exp_vc;
    for (int t = 0; t < 10; t++) begin
      w  = $urandom_range(0, 3) == 0 ? -1 : int'($urandom_range(0, 10));
      r  = $urandom_range(0, 6) == 0 ? -1 : int'($urandom_range(0, 24));
      if (r < 0) w = -1;
      rd = $urandom;
      wr = 1'($urandom_range(0, 1));
      // Timeout only if 16 no-wait, not-ready cycles pass first; wait, once raised, holds until ready.
      tmo = (r < 0) || (r > TIMEOUT - 1 && (w < 0 || w >= r));
      exp_vc = tmo ? TIMEOUT : r + 1;
      if (tmo) push_exp(1'b1, 1'b0, 32'd0);
      else push_exp(1'b0, wr, rd);
      issue_req($urandom, $urandom, $urandom);
      run_responder(w, r, rd, wr, 60, vc);
      wait_resp(20, got, obs);
      exp = exp_q.pop_front();
      n_cmp++;
      if (!got || obs !== exp || vc !== exp_vc) begin
        n_err++;
        $display("FAIL b2b[%0d] w=%0d r=%0d: got %b %h cycles %0d want %h cycles %0d",
                 t, w, r, got, obs, vc, exp, exp_vc);
      end
      handshake();
    end
  endtask

  initial begin
    resetn     = 1'b0;
    req_valid  = 1'b0;
    req_insn   = '0;
    req_rs1    = '0;
    req_rs2    = '0;
    resp_ready = 1'b0;
    pcpi_wr    = 1'b0;
    pcpi_rd    = '0;
    pcpi_wait  = 1'b0;
    pcpi_ready = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    test_reset();
    test_div();
    test_timeout();
    test_slow_wait();
    test_ready_at_limit();
    test_backpressure();
    test_reset_mid_issue();
    test_back_to_back();
`ifdef PCPI_INIT_STATS_EN
    n_cmp++;
    if (stat_done !== 32'(n_done_exp) || stat_timeout !== 32'(n_to_exp)) begin
      n_err++;
      $display("FAIL stats: got %0d %0d want %0d %0d", stat_done, stat_timeout, n_done_exp, n_to_exp);
    end
`endif
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
